// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg
//   Shared constants for the Wishbone down-counting timer:
//   register byte offsets, CTRL bit positions, the PRESCALE field LSB,
//   and a byte-lane merge helper used by every writable register.
package wb_timer_pkg;

    localparam int DATA_W = 32;

    // Register byte offsets (decoded from address bits [3:2]).
    localparam logic [3:0] OFS_CTRL   = 4'h0;
    localparam logic [3:0] OFS_LOAD   = 4'h4;
    localparam logic [3:0] OFS_COUNT  = 4'h8;
    localparam logic [3:0] OFS_STATUS = 4'hC;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT          = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT      = 2;
    localparam int CTRL_PRESCALE_LSB    = 8;

    // STATUS bit positions.
    localparam int STATUS_EXPIRED_BIT = 0;

    // Replace only the byte lanes selected by sel; others keep cur.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] wdat,
        input logic [3:0]        sel
    );
        logic [DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// wb_timer_prescaler
//   Divides clk into one-cycle ticks: counts 0..prescale and ticks in the
//   cycle the count reaches prescale, then restarts from 0.
// Ports:
//   clk       system clock
//   rst_i     asynchronous active-high reset
//   en        run enable; while low the count is held at 0
//   clr       synchronous restart of the count (timer being enabled)
//   prescale  terminal value; 0 ticks every cycle
//   tick      one-cycle pulse at the terminal value
module wb_timer_prescaler #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic                      en,
    input  logic                      clr,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] cnt_q;

    // >= rather than == so that lowering PRESCALE below the running count
    // restarts the period immediately instead of wrapping through 2^N.
    assign tick = en & ~clr & (cnt_q >= prescale);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (!en || clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// wb_timer
//   Wishbone-attached 32-bit down-counting timer with prescaler,
//   one-shot / auto-reload modes and a level interrupt.
//   Registers: 0x0 CTRL, 0x4 LOAD, 0x8 COUNT, 0xC STATUS (EXPIRED, W1C).
// Ports:
//   clk                 system clock
//   rst_i               asynchronous active-high reset
//   wb_adr_i            byte address; [3:2] register, [11:4] nonzero -> error
//   wb_dat_i/wb_dat_o   write / read data (read data nonzero only with ack)
//   wb_sel_i            byte-lane enables for writes
//   wb_we_i, wb_cyc_i, wb_stb_i   Wishbone request
//   wb_ack_o, wb_err_o  registered single-cycle responses
//   irq_o               registered EXPIRED & IRQ_EN
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic                     irq_o
);

    logic                      en_q;
    logic                      auto_reload_q;
    logic                      irq_en_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [DATA_W-1:0]         load_q;
    logic [DATA_W-1:0]         count_q;
    logic                      expired_q;

    logic              req;
    logic              unmapped;
    logic [3:0]        reg_ofs;
    logic              wr;
    logic              ctrl_wr, load_wr, count_wr, status_wr;
    logic              w1c;
    logic              tick;
    logic              expire;
    logic              presc_clr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ctrl_val;
    logic [DATA_W-1:0] ctrl_wdata;
    logic [DATA_W-1:0] rd_data;

    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[WB_ADDR_WIDTH-1:12], wb_adr_i[1:0]};

    // A new request is accepted only when no response is currently out,
    // which forces one idle cycle between back-to-back accesses.
    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign unmapped = |wb_adr_i[11:4];
    assign reg_ofs  = {wb_adr_i[3:2], 2'b00};
    assign wdata    = wb_dat_i;

    assign wr        = req & wb_we_i & ~unmapped;
    assign ctrl_wr   = wr & (reg_ofs == OFS_CTRL);
    assign load_wr   = wr & (reg_ofs == OFS_LOAD);
    assign count_wr  = wr & (reg_ofs == OFS_COUNT);
    assign status_wr = wr & (reg_ofs == OFS_STATUS);
    assign w1c       = status_wr & wb_sel_i[0] & wdata[STATUS_EXPIRED_BIT];

    always_comb begin
        ctrl_val = '0;
        ctrl_val[CTRL_EN_BIT]          = en_q;
        ctrl_val[CTRL_AUTO_RELOAD_BIT] = auto_reload_q;
        ctrl_val[CTRL_IRQ_EN_BIT]      = irq_en_q;
        ctrl_val[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH] = prescale_q;
    end

    assign ctrl_wdata = byte_merge(ctrl_val, wdata, wb_sel_i);

    always_comb begin
        rd_data = '0;
        case (reg_ofs)
            OFS_CTRL:   rd_data = ctrl_val;
            OFS_LOAD:   rd_data = load_q;
            OFS_COUNT:  rd_data = count_q;
            OFS_STATUS: rd_data[STATUS_EXPIRED_BIT] = expired_q;
            default:    rd_data = '0;
        endcase
    end

    // Restart the prescaler when software turns the timer on.
    assign presc_clr = ctrl_wr & ~en_q & ctrl_wdata[CTRL_EN_BIT];

    wb_timer_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst_i    (rst_i),
        .en       (en_q),
        .clr      (presc_clr),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // A bus write to COUNT swallows a coincident tick, including an expiry.
    assign expire = tick & ~count_wr & (count_q == '0);

    // Bus response
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req & ~unmapped;
            wb_err_o <= req & unmapped;
            wb_dat_o <= (req & ~wb_we_i & ~unmapped) ? rd_data : '0;
        end
    end

    // CTRL: a bus write overrides the hardware EN clear on one-shot expiry.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            en_q          <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            prescale_q    <= '0;
        end else if (ctrl_wr) begin
            en_q          <= ctrl_wdata[CTRL_EN_BIT];
            auto_reload_q <= ctrl_wdata[CTRL_AUTO_RELOAD_BIT];
            irq_en_q      <= ctrl_wdata[CTRL_IRQ_EN_BIT];
            prescale_q    <= ctrl_wdata[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
        end else if (expire && !auto_reload_q) begin
            en_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            load_q <= '0;
        end else if (load_wr) begin
            load_q <= byte_merge(load_q, wdata, wb_sel_i);
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (count_wr) begin
            count_q <= byte_merge(count_q, wdata, wb_sel_i);
        end else if (tick) begin
            if (count_q != '0) begin
                count_q <= count_q - 32'd1;
            end else if (auto_reload_q) begin
                count_q <= load_q;
            end
        end
    end

    // Set has priority over a coincident W1C.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            expired_q <= 1'b0;
        end else if (expire) begin
            expired_q <= 1'b1;
        end else if (w1c) begin
            expired_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= expired_q & irq_en_q;
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer
//   Directed self-checking bench for wb_timer: reset state, one-shot
//   expiry timing, auto-reload with prescaler, set-wins on W1C, bus
//   errors and byte lanes, and reset during an outstanding access.
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        irq_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_timer dut (
        .clk      (clk),
        .rst_i    (rst_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .irq_o    (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One bus access; returns after the response cycle has been sampled.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic err);
        logic got;
        got  = 1'b0;
        rdat = '0;
        err  = 1'b0;
        @(posedge clk); #1;
        wb_adr_i = adr; wb_dat_i = wdat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) begin
                got  = 1'b1;
                rdat = wb_dat_o;
                err  = wb_err_o;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check("bus_response", {31'd0, got}, 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
        logic [31:0] d;
        logic        e;
        wb_xfer(adr, 1'b1, wdat, sel, d, e);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
        logic e;
        wb_xfer(adr, 1'b0, 32'd0, 4'hF, d, e);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          spurious;

        rst_i = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        // Reset state
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        for (int r = 0; r < 4; r++) begin
            wb_read(r * 4, d);
            check($sformatf("rst_reg%0d", r), d, 32'd0);
        end

        // One-shot expiry: LOAD=5, COUNT=5, CTRL=EN|IRQ_EN, PRESCALE=0
        wb_write(32'h4, 32'd5, 4'hF);
        wb_write(32'h8, 32'd5, 4'hF);
        wb_write(32'h0, 32'h5, 4'hF);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            if (i == 5) check("oneshot_exp_c5", {31'd0, dut.expired_q}, 32'd0);
            if (i == 6) check("oneshot_exp_c6", {31'd0, dut.expired_q}, 32'd1);
            if (i == 6) check("oneshot_irq_c6", {31'd0, irq_o}, 32'd0);
            if (i == 7) check("oneshot_irq_c7", {31'd0, irq_o}, 32'd1);
        end
        wb_read(32'h0, d);
        check("oneshot_ctrl", d, 32'h4);
        wb_read(32'h8, d);
        check("oneshot_count", d, 32'd0);
        wb_read(32'hC, d);
        check("oneshot_status", d, 32'd1);
        wb_write(32'hC, 32'd1, 4'hF);
        wb_read(32'hC, d);
        check("oneshot_w1c", d, 32'd0);

        // Auto-reload, PRESCALE=3, LOAD=2: tick every 4 cycles, expiry every 12
        wb_write(32'h4, 32'd2, 4'hF);
        wb_write(32'h8, 32'd2, 4'hF);
        wb_write(32'h0, 32'h303, 4'hF);
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk); #1;
            if (i == 3)  check("ar_count_c3", dut.count_q, 32'd2);
            if (i == 4)  check("ar_count_c4", dut.count_q, 32'd1);
            if (i == 8)  check("ar_count_c8", dut.count_q, 32'd0);
            if (i == 11) check("ar_exp_c11", {31'd0, dut.expired_q}, 32'd0);
            if (i == 12) check("ar_exp_c12", {31'd0, dut.expired_q}, 32'd1);
            if (i == 12) check("ar_count_c12", dut.count_q, 32'd2);
            if (i == 16) check("ar_count_c16", dut.count_q, 32'd1);
            if (i == 23) check("ar_count_c23", dut.count_q, 32'd0);
            if (i == 24) check("ar_count_c24", dut.count_q, 32'd2);
        end
        wb_read(32'h0, d);
        check("ar_ctrl", d, 32'h303);
        wb_write(32'h0, 32'h0, 4'hF);
        wb_write(32'hC, 32'd1, 4'hF);

        // Set wins: W1C lands on the expiry edge
        wb_write(32'h4, 32'd0, 4'hF);
        wb_write(32'h8, 32'd1, 4'hF);
        wb_write(32'h0, 32'h5, 4'hF);
        wb_write(32'hC, 32'd1, 4'hF);
        wb_read(32'hC, d);
        check("setwins_status", d, 32'd1);
        check("setwins_irq", {31'd0, irq_o}, 32'd1);
        wb_write(32'hC, 32'd1, 4'hF);
        check("w1c_irq_hold", {31'd0, irq_o}, 32'd1);
        @(posedge clk); #1;
        check("w1c_irq_drop", {31'd0, irq_o}, 32'd0);
        wb_read(32'hC, d);
        check("w1c_status", d, 32'd0);

        // Bus error and byte lanes
        wb_xfer(32'h10, 1'b0, 32'd0, 4'hF, d, e);
        check("err_flag", {31'd0, e}, 32'd1);
        check("err_data", d, 32'd0);
        wb_write(32'h4, 32'h11223344, 4'hF);
        wb_write(32'h4, 32'hAABBCCDD, 4'b0010);
        wb_read(32'h4, d);
        check("sel_byte1", d, 32'h1122CC44);
        wb_xfer(32'h14, 1'b1, 32'hFFFFFFFF, 4'hF, d, e);
        check("err_wr_flag", {31'd0, e}, 32'd1);
        wb_read(32'h4, d);
        check("err_wr_noupd", d, 32'h1122CC44);
        wb_read(32'h8, d);
        check("load_keeps_count", d, 32'd0);

        // Reset mid-count with irq asserted and an access outstanding
        wb_write(32'h8, 32'd0, 4'hF);
        wb_write(32'h0, 32'h5, 4'hF);
        wb_write(32'h8, 32'd100, 4'hF);
        wb_write(32'h0, 32'hFF05, 4'hF);
        wb_read(32'h8, d);
        check("pre_rst_count", d, 32'd100);
        check("pre_rst_irq", {31'd0, irq_o}, 32'd1);
        @(posedge clk); #1;
        wb_adr_i = 32'h8; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        #3 rst_i = 1'b1;
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("midrst_irq", {31'd0, irq_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) spurious++;
        end
        check("midrst_no_ack", spurious, 32'd0);
        for (int r = 0; r < 4; r++) begin
            wb_read(r * 4, d);
            check($sformatf("midrst_reg%0d", r), d, 32'd0);
        end
        check("midrst_irq_after", {31'd0, irq_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
